// File: rtl/grf_hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard and its MDU busy timer.
package grf_hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    TUSE_D    = 2'd0,
    TUSE_E    = 2'd1,
    TUSE_M    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  localparam int unsigned TNEW_LINK = 0;
  localparam int unsigned TNEW_ALU  = 1;
  localparam int unsigned TNEW_LOAD = 2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/grf_hazard_scoreboard_if.sv
// D-stage request bundle into the scoreboard plus its stall/busy replies.
interface grf_hazard_scoreboard_if #(
  parameter int unsigned TNEW_W = 2
);
  logic              D_valid;
  logic [4:0]        D_rs;
  logic [4:0]        D_rt;
  logic [1:0]        D_rs_tuse;
  logic [1:0]        D_rt_tuse;
  logic              D_wr_en;
  logic [4:0]        D_wr_reg;
  logic [TNEW_W-1:0] D_wr_lat;
  logic              D_md_start;
  logic              D_md_is_div;
  logic              D_md_use;
  logic              stall;
  logic              md_busy;

  modport master (
    output D_valid, D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_wr_en, D_wr_reg,
           D_wr_lat, D_md_start, D_md_is_div, D_md_use,
    input  stall, md_busy
  );

  modport slave (
    input  D_valid, D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_wr_en, D_wr_reg,
           D_wr_lat, D_md_start, D_md_is_div, D_md_use,
    output stall, md_busy
  );
endinterface

// File: rtl/grf_hazard_mdu_timer.sv
// Busy-cycle counter for the multi-cycle multiply/divide unit.
module grf_hazard_mdu_timer
  import grf_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic busy
);
  localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] mdCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdCnt <= '0;
    end else if (start) begin
      mdCnt <= isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - CNT_W'(1);
    end
  end

  assign busy = (mdCnt != '0);

endmodule

// File: rtl/grf_hazard_scoreboard.sv
// D-stage hazard controller: per-register forwardability scoreboard plus MDU busy
// tracking, producing a single stall for the F/D enable and E flush logic.
module grf_hazard_scoreboard
  import grf_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned TNEW_W      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  grf_hazard_scoreboard_if.slave  bus
);
  localparam int unsigned CMP_W = (TNEW_W > 2) ? TNEW_W : 2;

  logic [TNEW_W-1:0] pend [32];
  tuse_e             rsUse;
  tuse_e             rtUse;
  logic              rsHaz;
  logic              rtHaz;
  logic              mdHaz;
  logic              mdBusy;
  logic              stallInt;
  logic              issue;

  // pend[0] is never loaded, so reads of $0 always see "ready".
  always_comb begin
    rsUse    = tuse_e'(bus.D_rs_tuse);
    rtUse    = tuse_e'(bus.D_rt_tuse);
    rsHaz    = (bus.D_rs != 5'd0) && (rsUse != TUSE_NONE) &&
               (CMP_W'(pend[bus.D_rs]) > CMP_W'(rsUse));
    rtHaz    = (bus.D_rt != 5'd0) && (rtUse != TUSE_NONE) &&
               (CMP_W'(pend[bus.D_rt]) > CMP_W'(rtUse));
    mdHaz    = bus.D_md_use && mdBusy;
    stallInt = bus.D_valid && (rsHaz || rtHaz || mdHaz);
    issue    = bus.D_valid && !stallInt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < 32; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 32; r++) begin
        if (issue && bus.D_wr_en && (bus.D_wr_reg == 5'(r)) && (r != 0)) begin
          pend[r] <= bus.D_wr_lat;
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - TNEW_W'(1);
        end
      end
    end
  end

  grf_hazard_mdu_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .start (issue && bus.D_md_start),
    .isDiv (bus.D_md_is_div),
    .busy  (mdBusy)
  );

  assign bus.stall   = stallInt;
  assign bus.md_busy = mdBusy;

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Randomized and directed bench for grf_hazard_scoreboard against a behavioural model.
module tb_grf_hazard_scoreboard;
  import grf_hazard_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Model: cycles until each register is forwardable, and remaining MDU busy cycles.
  int pendM [32];
  int mdM;

  grf_hazard_scoreboard_if #(.TNEW_W(2)) bus ();

  grf_hazard_scoreboard #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .TNEW_W      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    for (int r = 0; r < 32; r++) pendM[r] = 0;
    mdM = 0;
  endtask

  // Entered at posedge+1; drives one D-stage slot, checks DUT against model,
  // advances model across the clock edge, returns at posedge+1.
  task automatic step(input bit v, input int rs, input int rsT, input int rt, input int rtT,
                      input bit we, input int wr, input int wl,
                      input bit ms, input bit isDiv, input bit mu, output bit st);
    bit expSt;
    bit iss;
    bus.D_valid     = v;
    bus.D_rs        = 5'(rs);
    bus.D_rs_tuse   = 2'(rsT);
    bus.D_rt        = 5'(rt);
    bus.D_rt_tuse   = 2'(rtT);
    bus.D_wr_en     = we;
    bus.D_wr_reg    = 5'(wr);
    bus.D_wr_lat    = 2'(wl);
    bus.D_md_start  = ms;
    bus.D_md_is_div = isDiv;
    bus.D_md_use    = mu;
    #1;
    expSt = v && ((rs != 0 && rsT != 3 && pendM[rs] > rsT) ||
                  (rt != 0 && rtT != 3 && pendM[rt] > rtT) ||
                  (mu && mdM != 0));
    chk("stall", int'(bus.stall), int'(expSt));
    chk("md_busy", int'(bus.md_busy), int'(mdM != 0));
    st  = expSt;
    iss = v && !expSt;
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      if (iss && we && wr == r) pendM[r] = wl;
      else if (pendM[r] > 0) pendM[r]--;
    end
    if (iss && ms) mdM = isDiv ? 10 : 5;
    else if (mdM > 0) mdM--;
    #1;
  endtask

  initial begin
    bit st;
    int n;
    checks = 0;
    errors = 0;
    clearModel();

    // Reset held with a request that would stall if the MDU were busy.
    reset = 1'b0;
    bus.D_valid = 1'b1; bus.D_rs = '0; bus.D_rt = '0;
    bus.D_rs_tuse = 2'd3; bus.D_rt_tuse = 2'd3;
    bus.D_wr_en = 1'b0; bus.D_wr_reg = '0; bus.D_wr_lat = '0;
    bus.D_md_start = 1'b0; bus.D_md_is_div = 1'b0; bus.D_md_use = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_stall", int'(bus.stall), 0);
      chk("rst_md_busy", int'(bus.md_busy), 0);
    end
    reset = 1'b1;

    for (int r = 0; r < 32; r++) begin
      step(1, r, 0, r, 0, 0, 0, 0, 0, 0, 0, st);
      chk("post_rst_read", int'(st), 0);
    end

    // Load-use
    step(1, 0, 3, 0, 3, 1, 1, TNEW_LOAD, 0, 0, 0, st); chk("lw_issue", int'(st), 0);
    step(1, 1, 1, 0, 3, 1, 3, TNEW_ALU, 0, 0, 0, st);  chk("loaduse_c1", int'(st), 1);
    step(1, 1, 1, 0, 3, 1, 3, TNEW_ALU, 0, 0, 0, st);  chk("loaduse_c2", int'(st), 0);

    // ALU result to a D-stage branch, then to an E-stage consumer
    step(1, 0, 3, 0, 3, 1, 2, TNEW_ALU, 0, 0, 0, st);  chk("add2_issue", int'(st), 0);
    step(1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 0, st);         chk("beq_tuse0_c1", int'(st), 1);
    step(1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 0, st);         chk("beq_tuse0_c2", int'(st), 0);
    step(1, 0, 3, 0, 3, 1, 2, TNEW_ALU, 0, 0, 0, st);  chk("add2b_issue", int'(st), 0);
    step(1, 0, 3, 2, 1, 0, 0, 0, 0, 0, 0, st);         chk("rt_tuse1", int'(st), 0);

    // $0 is never tracked
    step(1, 0, 3, 0, 3, 1, 0, 3, 0, 0, 0, st);         chk("wr_zero", int'(st), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);         chk("rd_zero", int'(st), 0);

    // mult then mflo, div then mflo
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 3, 0, 3, 0, 0, 0, 1, k[0], 1, st);    chk("md_start", int'(st), 0);
      n = 0;
      for (int c = 0; c < 20; c++) begin
        step(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, st);
        if (!st) break;
        n++;
      end
      chk(k == 0 ? "mult_stalls" : "div_stalls", n, k == 0 ? 5 : 10);
    end

    // Async reset in the middle of a divide
    step(1, 0, 3, 0, 3, 0, 0, 0, 1, 1, 1, st);         chk("div_issue", int'(st), 0);
    repeat (3) step(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, st);
    bus.D_md_start = 1'b0; bus.D_md_use = 1'b1; bus.D_valid = 1'b1;
    #1;
    chk("pre_async_stall", int'(bus.stall), 1);
    chk("pre_async_busy", int'(bus.md_busy), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_stall", int'(bus.stall), 0);
    chk("async_busy", int'(bus.md_busy), 0);
    clearModel();
    @(posedge clk); #1;
    reset = 1'b1;
    step(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, st);         chk("mflo_after_rst", int'(st), 0);

    // Randomized traffic over a small register window to provoke hazards
    for (int c = 0; c < 3000; c++) begin
      bit ms;
      bit mu;
      ms = ($urandom_range(0, 15) == 0);
      mu = ms || ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 4) != 0,
           $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3),
           ms, $urandom_range(0, 1) == 1, mu, st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
